conv_datapath: RTL and testbench

- Arithmetic stage directly downstream of control_unit. It consumes the one-hot step bus T[15:0] and computes a valid 3x3 convolution of a 4x4 image of unsigned 4-bit pixels.
- Holds a 16-entry pixel file and a 9-entry kernel file, loaded over simple write ports while idle.
- Runs one multiply-accumulate per T step and emits the 2x2 output map, one result per full T sweep.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_mac.sv | 44 ++++
 rtl/conv_datapath.sv | 160 ++++++++++++++++
 tb/tb_conv_datapath.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, step classification and window addressing for the 3x3-on-4x4 convolution
// datapath.
package conv_pkg;

    localparam int unsigned PIX_W_DEF  = 4;
    localparam int unsigned COEF_W_DEF = 4;
    localparam int unsigned ACC_W_DEF  = 11;

    localparam int unsigned IMG_DIM = 4;
    localparam int unsigned K_DIM   = 3;
    localparam int unsigned OUT_DIM = 2;
    localparam int unsigned TAP_CNT = 9;

    localparam int unsigned STEP_CLR  = 0;
    localparam int unsigned STEP_TAP0 = 1;
    localparam int unsigned STEP_RES  = 10;

    typedef enum logic [1:0] {
        StepNone,
        StepClr,
        StepTap,
        StepRes
    } step_e;

    // Pixel index for tap t of output (r,c), where res = {r,c}. The image width is 4, so the
    // index is the row/column pair concatenated.
    function automatic logic [3:0] pix_index(input logic [1:0] res, input logic [3:0] tap);
        logic [3:0] ki;
        logic [3:0] kj;
        logic [1:0] row;
        logic [1:0] col;
        ki  = tap / 4'(K_DIM);
        kj  = tap % 4'(K_DIM);
        row = {1'b0, res[1]} + ki[1:0];
        col = {1'b0, res[0]} + kj[1:0];
        return {row, col};
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Unsigned multiplier feeding an accumulator register; clear has priority over accumulate.
module conv_mac
    import conv_pkg::*;
#(
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [PIX_W-1:0]  pix,
    input  logic [COEF_W-1:0] coef,
    output logic [ACC_W-1:0]  acc
);

    localparam int unsigned PROD_W = PIX_W + COEF_W;

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  acc_q;

    always_comb begin
        prod  = PROD_W'(pix) * PROD_W'(coef);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv_datapath.sv
// Valid 3x3 convolution of a 4x4 image, one MAC per one-hot T step and one result per sweep,
// with pixel/kernel files writable only while idle.
module conv_datapath
    import conv_pkg::*;
#(
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       T,
    input  logic              pix_we,
    input  logic [3:0]        pix_addr,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    output logic [1:0]        out_idx,
    output logic [ACC_W-1:0]  out_data,
    output logic              done
);

    logic [PIX_W-1:0]  pix_q  [16];
    logic [PIX_W-1:0]  pix_d  [16];
    logic [COEF_W-1:0] coef_q [TAP_CNT];
    logic [COEF_W-1:0] coef_d [TAP_CNT];

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             window_q, window_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_idx_q, out_idx_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;

    logic             step_ok;
    logic [3:0]       step_idx;
    step_e            step_kind;
    logic [3:0]       tap;
    logic [3:0]       pix_sel;
    logic             mac_clr;
    logic             mac_en;
    logic [ACC_W-1:0] acc;

    // Anything other than exactly one hot bit is not a step.
    always_comb begin
        step_ok  = (T != '0) && ((T & (T - 16'd1)) == '0);
        step_idx = '0;
        for (int k = 0; k < 16; k++) begin
            if (T[k]) begin
                step_idx = 4'(k);
            end
        end
        step_kind = StepNone;
        if (step_ok) begin
            if (step_idx == 4'(STEP_CLR)) begin
                step_kind = StepClr;
            end else if (step_idx >= 4'(STEP_TAP0) && step_idx < 4'(STEP_TAP0 + TAP_CNT)) begin
                step_kind = StepTap;
            end else if (step_idx == 4'(STEP_RES)) begin
                step_kind = StepRes;
            end
        end
        tap     = (step_kind == StepTap) ? step_idx - 4'(STEP_TAP0) : '0;
        pix_sel = pix_index(cnt_q, tap);
        mac_clr = busy_q && (step_kind == StepClr);
        mac_en  = window_q && (step_kind == StepTap);
    end

    conv_mac #(
        .PIX_W  (PIX_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .pix   (pix_q[pix_sel]),
        .coef  (coef_q[tap]),
        .acc   (acc)
    );

    always_comb begin
        pix_d       = pix_q;
        coef_d      = coef_q;
        busy_d      = busy_q;
        done_d      = done_q;
        window_d    = window_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;

        if (!busy_q) begin
            if (pix_we) begin
                pix_d[pix_addr] = pix_data;
            end
            if (coef_we && coef_addr < 4'(TAP_CNT)) begin
                coef_d[coef_addr] = coef_data;
            end
            // The start cycle is never this run's clear step: window opens on a later T[0].
            if (start) begin
                busy_d   = 1'b1;
                done_d   = 1'b0;
                cnt_d    = '0;
                window_d = 1'b0;
            end
        end else begin
            if (step_kind == StepClr) begin
                window_d = 1'b1;
            end else if (step_kind == StepRes && window_q) begin
                out_data_d  = acc;
                out_idx_d   = cnt_q;
                out_valid_d = 1'b1;
                cnt_d       = cnt_q + 2'd1;
                window_d    = 1'b0;
                if (cnt_q == 2'(OUT_DIM * OUT_DIM - 1)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_q       <= '{default: '0};
            coef_q      <= '{default: '0};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            window_q    <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            pix_q       <= pix_d;
            coef_q      <= coef_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            window_q    <= window_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_datapath.sv
// Randomized self-checking bench for conv_datapath against a direct convolution model.
module tb_conv_datapath;

    localparam int unsigned PW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   T;
    logic          pix_we;
    logic [3:0]    pix_addr;
    logic [PW-1:0] pix_data;
    logic          coef_we;
    logic [3:0]    coef_addr;
    logic [CW-1:0] coef_data;
    logic          start;
    logic          busy;
    logic          out_valid;
    logic [1:0]    out_idx;
    logic [AW-1:0] out_data;
    logic          done;

    always #5 clk = ~clk;

    conv_datapath #(
        .PIX_W  (PW),
        .COEF_W (CW),
        .ACC_W  (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .T         (T),
        .pix_we    (pix_we),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .done      (done)
    );

    int n_vec = 0;
    int n_bad = 0;

    int ref_pix  [16];
    int ref_coef [9];

    typedef struct {
        int          idx;
        int          data;
        logic [15:0] t;
    } res_t;

    res_t got_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Direct definition of a valid 3x3 convolution output at position p = r*2+c.
    function automatic int ref_result(input int p);
        int r = p / 2;
        int c = p % 2;
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += ref_pix[(r + i) * 4 + (c + j)] * ref_coef[i * 3 + j];
        return s;
    endfunction

    always @(negedge clk) begin
        if (reset && out_valid) begin
            got_q.push_back('{idx: int'(out_idx), data: int'(out_data), t: T});
            if (out_idx == 2'd3) begin
                check_eq("done_with_last", 32'(done), 32'd1);
                check_eq("busy_with_last", 32'(busy), 32'd0);
            end
        end
    end

    task automatic tick(input logic [15:0] t);
        T = t;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pix_we  = 1'b0;
        coef_we = 1'b0;
    endtask

    // mode 0: ramp pixels + identity kernel, 1: all 15, 2: random (nonzero).
    task automatic load(input int mode);
        for (int k = 0; k < 16; k++) begin
            int pv;
            int cv;
            pv = (mode == 0) ? k : (mode == 1) ? 15 : int'($urandom_range(1, 15));
            cv = (mode == 0) ? ((k == 4) ? 1 : 0) : (mode == 1) ? 15 : int'($urandom_range(1, 15));
            pix_we    = 1'b1;
            pix_addr  = 4'(k);
            pix_data  = PW'(pv);
            ref_pix[k] = pv;
            coef_we   = 1'b1;
            coef_addr = 4'(k);
            coef_data = CW'(cv);
            if (k < 9) ref_coef[k] = cv;
            tick(16'h0000);
        end
    endtask

    task automatic run(input bit mid_start, input bit illegal, input bit lockout,
                       input string name);
        got_q.delete();
        if (mid_start) begin
            for (int k = 0; k < 16; k++) begin
                if (k == 4) start = 1'b1;
                tick(16'h0001 << k);
            end
        end else begin
            start = 1'b1;
            tick(16'h0000);
        end
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 16; k++) begin
                if (lockout && s == 1 && k == 7) begin
                    pix_we   = 1'b1;
                    pix_addr = 4'd5;
                    pix_data = '0;
                    start    = 1'b1;
                end
                tick(16'h0001 << k);
                if (illegal && s == 1 && k == 4) begin
                    tick(16'h0000);
                    tick(16'h0006);
                end
            end
        end
        tick(16'h0000);
        tick(16'h0000);
        check_eq({name, "_count"}, 32'(got_q.size()), 32'd4);
        for (int p = 0; p < got_q.size() && p < 4; p++) begin
            check_eq({name, "_idx"}, 32'(got_q[p].idx), 32'(p));
            check_eq({name, "_data"}, 32'(got_q[p].data), 32'(ref_result(p)));
            check_eq({name, "_at_T11"}, 32'(got_q[p].t), 32'h0800);
        end
        check_eq({name, "_done"}, 32'(done), 32'd1);
        check_eq({name, "_busy"}, 32'(busy), 32'd0);
        check_eq({name, "_valid_low"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_busy"}, 32'(busy), 32'd0);
        check_eq({name, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({name, "_idx"}, 32'(out_idx), 32'd0);
        check_eq({name, "_data"}, 32'(out_data), 32'd0);
        check_eq({name, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        T         = '0;
        pix_we    = 1'b0;
        pix_addr  = '0;
        pix_data  = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        start     = 1'b0;
        for (int k = 0; k < 16; k++) ref_pix[k] = 0;
        for (int k = 0; k < 9; k++) ref_coef[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        load(0);
        run(1'b0, 1'b0, 1'b0, "ident");

        load(1);
        run(1'b0, 1'b0, 1'b0, "sat");

        for (int it = 0; it < 3; it++) begin
            load(2);
            run(it == 0, it == 1, 1'b0, "rand");
        end

        load(2);
        run(1'b0, 1'b0, 1'b1, "lockout");
        pix_we   = 1'b1;
        pix_addr = 4'd5;
        pix_data = '0;
        ref_pix[5] = 0;
        tick(16'h0000);
        run(1'b0, 1'b0, 1'b0, "post_lock");

        // Abort during the third result's T[5].
        load(2);
        got_q.delete();
        start = 1'b1;
        tick(16'h0000);
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 16; k++) tick(16'h0001 << k);
        for (int k = 0; k < 5; k++) tick(16'h0001 << k);
        T = 16'h0020;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 16; k++) ref_pix[k] = 0;
        for (int k = 0; k < 9; k++) ref_coef[k] = 0;
        run(1'b0, 1'b0, 1'b0, "rst_cleared");
        load(2);
        run(1'b0, 1'b0, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
